// File: rtl/calc_pkg.sv
// calc_pkg: shared constants for the queue calculator and its program
// sequencer.
//   - OP_*       : calculator op codes; OP_HALT is sequencer-only (never applied)
//   - S_*        : sequencer FSM state encodings
//   - QUEUE_SIZE : default depth of the calculator queue
package calc_pkg;

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_DIV  = 3'd5;
    localparam logic [2:0] OP_MOD  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam int QUEUE_SIZE = 5;

endpackage

// File: rtl/calc_prog_mem.sv
// calc_prog_mem: DEPTH x (3+WIDTH) instruction store.
//   clk          : write clock
//   we/waddr     : synchronous write strobe and slot
//   wop/wdata    : op code and push operand written to the slot
//   raddr        : combinational read address
//   rop/rdata    : op code and operand at raddr
// Contents are deliberately not reset so a program survives reset.
module calc_prog_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [2:0]       wop,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [2:0]       rop,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH+2:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= {wop, wdata};
    end

    assign rop   = mem_q[raddr][WIDTH+2:WIDTH];
    assign rdata = mem_q[raddr][WIDTH-1:0];

endmodule

// File: rtl/calc_seq.sv
// calc_seq: program sequencer for the 5-entry queue calculator.
// Issues one stored instruction every two cycles (ISSUE applies, CHECK
// inspects the calculator's valid flag) and stops on HALT, on the last
// slot, or on a calculator error.
//   clk, reset          : clock, asynchronous active-high reset
//   prog_we/addr/op/data: instruction store write port (dropped while busy)
//   start               : run request (ignored while busy)
//   step                : single-step gate, only with CALC_SEQ_SINGLE_STEP_EN
//   calc_reset          : registered clear pulse to the calculator
//   calc_op/in/apply    : op, operand and apply strobe to the calculator
//   calc_valid/tail     : calculator status and tail value
//   busy/done/error     : run status; done/error held until next start
//   pc                  : current or last instruction index
//   result              : calc_tail captured on a clean finish
// Optional feature macro: CALC_SEQ_SINGLE_STEP_EN.
module calc_seq
    import calc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PROG_DEPTH = 16,
    parameter int AW         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [2:0]       prog_op,
    input  logic [WIDTH-1:0] prog_data,
    input  logic             start,
`ifdef CALC_SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             calc_reset,
    output logic [2:0]       calc_op,
    output logic [WIDTH-1:0] calc_in,
    output logic             calc_apply,
    input  logic             calc_valid,
    input  logic [WIDTH-1:0] calc_tail,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [AW-1:0]    pc,
    output logic [WIDTH-1:0] result
);

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             clr_q, clr_d;

    logic [2:0]       mem_op;
    logic [WIDTH-1:0] mem_data;
    logic             go;
    logic             is_halt;
    logic             issue;

    // Busy is decoded from state so write/start gating reacts the same
    // cycle the run begins and ends.
    assign busy = (state_q == S_CLEAR) || (state_q == S_ISSUE) || (state_q == S_CHECK);

    calc_prog_mem #(
        .WIDTH (WIDTH),
        .DEPTH (PROG_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wop   (prog_op),
        .wdata (prog_data),
        .raddr (pc_q),
        .rop   (mem_op),
        .rdata (mem_data)
    );

`ifdef CALC_SEQ_SINGLE_STEP_EN
    assign go = step;
`else
    assign go = 1'b1;
`endif

    assign is_halt = (mem_op == OP_HALT);
    // Apply and its operands are decoded from the registered state, so an
    // asynchronous reset drops them at once.
    assign issue      = (state_q == S_ISSUE) && go && !is_halt;
    assign calc_apply = issue;
    assign calc_op    = issue ? mem_op   : 3'd0;
    assign calc_in    = issue ? mem_data : '0;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        done_d   = done_q;
        error_d  = error_q;
        result_d = result_q;
        clr_d    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    pc_d    = '0;
                    clr_d   = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_ISSUE;
            S_ISSUE: begin
                if (go) begin
                    if (is_halt) begin
                        result_d = calc_tail;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (!calc_valid) begin
                    error_d = 1'b1;
                    state_d = S_ERR;
                end else if (pc_q == AW'(PROG_DEPTH - 1)) begin
                    result_d = calc_tail;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    pc_d    = pc_q + AW'(1);
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            done_q   <= done_d;
            error_q  <= error_d;
            result_q <= result_d;
            clr_q    <= clr_d;
        end
    end

    // clr_q is high exactly for the CLEAR cycle.
    assign calc_reset = clr_q;
    assign done       = done_q;
    assign error      = error_q;
    assign pc         = pc_q;
    assign result     = result_q;

endmodule

// File: tb/tb_calc_seq.sv
module tb_calc_seq;
    import calc_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [2:0] prog_op = '0;
    logic [7:0] prog_data = '0;
    logic       start = 1'b0;
    logic       calc_reset, calc_apply, calc_valid;
    logic [2:0] calc_op;
    logic [7:0] calc_in, calc_tail;
    logic       busy, done, error;
    logic [3:0] pc;
    logic [7:0] result;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    calc_seq #(.WIDTH(8), .PROG_DEPTH(16), .AW(4)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_op(prog_op), .prog_data(prog_data), .start(start),
        .calc_reset(calc_reset), .calc_op(calc_op), .calc_in(calc_in),
        .calc_apply(calc_apply), .calc_valid(calc_valid), .calc_tail(calc_tail),
        .busy(busy), .done(done), .error(error), .pc(pc), .result(result)
    );

    // Behavioural queue calculator: binary ops combine tail (a) with the
    // entry below it (b) as a OP b; errors are sticky until cleared.
    logic [7:0] m_q [QUEUE_SIZE];
    int         m_cnt;
    logic       m_vld;
    int         apply_cnt = 0;
    int         clr_cnt = 0;

    always @(posedge clk or posedge reset) begin
        logic [7:0] a, b, r;
        logic bad;
        if (reset || calc_reset) begin
            m_cnt <= 0;
            m_vld <= 1'b1;
        end else if (calc_apply && m_vld) begin
            case (calc_op)
                OP_PUSH: if (m_cnt == QUEUE_SIZE) m_vld <= 1'b0;
                         else begin m_q[m_cnt] <= calc_in; m_cnt <= m_cnt + 1; end
                OP_POP:  if (m_cnt == 0) m_vld <= 1'b0; else m_cnt <= m_cnt - 1;
                default: begin
                    if (m_cnt < 2) m_vld <= 1'b0;
                    else begin
                        a = m_q[m_cnt-1];
                        b = m_q[m_cnt-2];
                        bad = 1'b0;
                        r = '0;
                        case (calc_op)
                            OP_ADD: r = a + b;
                            OP_MUL: r = a * b;
                            OP_SUB: r = a - b;
                            OP_DIV: if (b == 0) bad = 1'b1; else r = a / b;
                            OP_MOD: if (b == 0) bad = 1'b1; else r = a % b;
                            default: bad = 1'b1;
                        endcase
                        if (bad) m_vld <= 1'b0;
                        else begin m_q[m_cnt-2] <= r; m_cnt <= m_cnt - 1; end
                    end
                end
            endcase
        end
    end

    always_comb begin
        calc_valid = m_vld;
        calc_tail  = (m_cnt > 0) ? m_q[m_cnt-1] : 8'd0;
    end

    always @(posedge clk) begin
        if (calc_apply) apply_cnt <= apply_cnt + 1;
        if (calc_reset) clr_cnt <= clr_cnt + 1;
    end

    task automatic prog(input int a, input logic [2:0] op, input logic [7:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'(a); prog_op = op; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Pulses start, then counts edges (from the one sampling start) until idle.
    task automatic run(output int edges);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        edges = 0;
        while (busy && edges < 100) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset;
        #2;
        nvec++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            nerr++; $display("FAIL reset_flags got busy=%b done=%b error=%b want 0 0 0", busy, done, error); end
        nvec++; if (pc !== 4'd0 || result !== 8'd0) begin
            nerr++; $display("FAIL reset_regs got pc=%0d result=%0d want 0 0", pc, result); end
        nvec++; if (calc_apply !== 1'b0 || calc_op !== 3'd0 || calc_in !== 8'd0 || calc_reset !== 1'b0) begin
            nerr++; $display("FAIL reset_calc got apply=%b op=%0d in=%0d clr=%b want 0", calc_apply, calc_op, calc_in, calc_reset); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_arith(input string nm, input logic [7:0] x, input logic [7:0] y,
                              input logic [2:0] op, input logic [7:0] exp);
        int e, a0;
        prog(0, OP_PUSH, x); prog(1, OP_PUSH, y); prog(2, op, 8'd0); prog(3, OP_HALT, 8'd0);
        a0 = apply_cnt;
        run(e);
        nvec++; if (result !== exp || done !== 1'b1 || error !== 1'b0) begin
            nerr++; $display("FAIL %s_result got result=%0d done=%b error=%b want %0d 1 0", nm, result, done, error, exp); end
        nvec++; if (e !== 8 || pc !== 4'd3) begin
            nerr++; $display("FAIL %s_timing got edges=%0d pc=%0d want 8 3", nm, e, pc); end
        nvec++; if (apply_cnt - a0 !== 3) begin
            nerr++; $display("FAIL %s_applies got %0d want 3", nm, apply_cnt - a0); end
    endtask

    task automatic test_div_zero;
        int e, a0;
        prog(0, OP_PUSH, 8'd0); prog(1, OP_PUSH, 8'd5); prog(2, OP_DIV, 8'd0);
        a0 = apply_cnt;
        run(e);
        repeat (4) @(negedge clk);
        nvec++; if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || pc !== 4'd2) begin
            nerr++; $display("FAIL div0 got error=%b done=%b busy=%b pc=%0d want 1 0 0 2", error, done, busy, pc); end
        nvec++; if (apply_cnt - a0 !== 3) begin
            nerr++; $display("FAIL div0_applies got %0d want 3", apply_cnt - a0); end
    endtask

    task automatic test_overflow;
        int e;
        for (int i = 0; i < 6; i++) prog(i, OP_PUSH, 8'(i + 1));
        run(e);
        nvec++; if (error !== 1'b1 || done !== 1'b0 || pc !== 4'd5) begin
            nerr++; $display("FAIL overflow got error=%b done=%b pc=%0d want 1 0 5", error, done, pc); end
        prog(0, OP_POP, 8'd0);
        run(e);
        nvec++; if (error !== 1'b1 || pc !== 4'd0) begin
            nerr++; $display("FAIL pop_empty got error=%b pc=%0d want 1 0", error, pc); end
    endtask

    // All 16 slots used without HALT: push 0, push 1, then push i / add pairs.
    task automatic test_full_store;
        int e, a0;
        prog(0, OP_PUSH, 8'd0); prog(1, OP_PUSH, 8'd1);
        for (int i = 2; i < 16; i++) prog(i, (i % 2 == 0) ? OP_PUSH : OP_ADD, 8'(i));
        a0 = apply_cnt;
        run(e);
        nvec++; if (done !== 1'b1 || result !== 8'd57 || pc !== 4'd15) begin
            nerr++; $display("FAIL full_store got done=%b result=%0d pc=%0d want 1 57 15", done, result, pc); end
        nvec++; if (e !== 33 || apply_cnt - a0 !== 16) begin
            nerr++; $display("FAIL full_store_timing got edges=%0d applies=%0d want 33 16", e, apply_cnt - a0); end
    endtask

    task automatic test_busy_ignored;
        int e, c0;
        prog(0, OP_PUSH, 8'd3); prog(1, OP_PUSH, 8'd4); prog(2, OP_ADD, 8'd0); prog(3, OP_HALT, 8'd0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        prog_we = 1'b1; prog_addr = 4'd0; prog_op = OP_PUSH; prog_data = 8'd100;
        @(negedge clk); prog_we = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        e = 2;
        while (busy && e < 100) begin @(negedge clk); e++; end
        nvec++; if (result !== 8'd7 || e !== 8) begin
            nerr++; $display("FAIL busy_ignored got result=%0d edges=%0d want 7 8", result, e); end
        c0 = clr_cnt;
        run(e);
        nvec++; if (clr_cnt - c0 !== 1 || result !== 8'd7 || done !== 1'b1) begin
            nerr++; $display("FAIL rerun got clr=%0d result=%0d done=%b want 1 7 1", clr_cnt - c0, result, done); end
    endtask

    task automatic test_start_with_write;
        int e;
        @(negedge clk);
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_op = OP_PUSH; prog_data = 8'd5;
        @(negedge clk); start = 1'b0; prog_we = 1'b0;
        e = 0;
        while (busy && e < 100) begin @(negedge clk); e++; end
        nvec++; if (result !== 8'd9 || e !== 8) begin
            nerr++; $display("FAIL start_write got result=%0d edges=%0d want 9 8", result, e); end
    endtask

    task automatic test_reset_mid;
        int e;
        prog(0, OP_PUSH, 8'd3);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        nvec++; if (calc_apply !== 1'b1) begin
            nerr++; $display("FAIL issue_apply got %b want 1", calc_apply); end
        reset = 1'b1; #1;
        nvec++; if (calc_apply !== 1'b0 || busy !== 1'b0) begin
            nerr++; $display("FAIL reset_in_issue got apply=%b busy=%b want 0 0", calc_apply, busy); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1; #1;
        nvec++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || calc_apply !== 1'b0 || pc !== 4'd0) begin
            nerr++; $display("FAIL reset_in_check got busy=%b done=%b error=%b apply=%b pc=%0d want 0", busy, done, error, calc_apply, pc); end
        @(negedge clk); reset = 1'b0;
        run(e);
        nvec++; if (result !== 8'd7 || e !== 8 || done !== 1'b1) begin
            nerr++; $display("FAIL after_reset got result=%0d edges=%0d done=%b want 7 8 1", result, e, done); end
    endtask

    initial begin
        test_reset;
        test_arith("add", 8'd3, 8'd4, OP_ADD, 8'd7);
        test_arith("sub", 8'd2, 8'd9, OP_SUB, 8'd7);
        test_arith("mul", 8'd20, 8'd13, OP_MUL, 8'd4);
        test_div_zero;
        test_overflow;
        test_full_store;
        test_busy_ignored;
        test_start_with_write;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/calc_seq.md
Name: calc_seq

Overview:
- Program sequencer for the 5-entry queue calculator (op codes 0..6: push, pop, add, mul, sub, div, mod).
- Holds a small writable instruction store and issues one instruction per two cycles on the calculator's op/in/apply interface.
- Checks the calculator's valid flag after each apply, and stops on HALT, on the end of the store or on an error.
- Reports the final tail value as the result; sits between a host/testbench and the calculator.

Parameters:
- WIDTH, 8, data width of operands, matching the calculator.
- PROG_DEPTH, 16, number of instruction slots; power of 2.
- AW, 4, program address width; must equal log2(PROG_DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- prog_we  in  1  write strobe for the instruction store; ignored while busy=1.
- prog_addr  in  AW  instruction slot to write.
- prog_op  in  3  op code to store; 0..6 are calculator ops, 7 is HALT.
- prog_data  in  WIDTH  push operand to store; don't-care for other ops.
- start  in  1  one-cycle run request; ignored while busy=1.
- calc_reset  out  1  registered clear pulse to the calculator's reset port.
- calc_op  out  3  op presented to the calculator.
- calc_in  out  WIDTH  operand presented to the calculator.
- calc_apply  out  1  one-cycle apply strobe.
- calc_valid  in  1  calculator valid flag (sticky low on error).
- calc_tail  in  WIDTH  calculator tail value.
- busy  out  1  run in progress.
- done  out  1  run finished cleanly; held until next start or reset.
- error  out  1  run aborted on calculator error; held until next start or reset.
- pc  out  AW  current or last instruction index.
- result  out  WIDTH  calc_tail captured on clean finish.

Behaviour:
- Reset values: state IDLE; pc=0, busy=0, done=0, error=0, result=0, calc_apply=0, calc_op=0, calc_in=0, calc_reset=0.
- Instruction store is not reset; its contents persist across runs and across reset.
- State IDLE, DONE or ERR, on start: clear done/error, set pc=0 and busy=1, go to CLEAR.
- CLEAR (1 cycle): calc_reset=1, then go to ISSUE. The calculator's queue and valid flag are therefore fresh for every run.
- ISSUE, when mem[pc].op == 7: result<=calc_tail, done<=1, busy<=0, go to DONE, with no apply.
- ISSUE, otherwise: drive calc_op/calc_in from mem[pc] with calc_apply=1 for exactly this cycle, then go to CHECK.
- CHECK: sample calc_valid, which the calculator updated on the apply edge.
  - calc_valid=0: error<=1, busy<=0, pc holds the failing index, go to ERR.
  - calc_valid=1 and pc == PROG_DEPTH-1: result<=calc_tail, done<=1, busy<=0, go to DONE.
  - Otherwise: pc<=pc+1, go to ISSUE.
- Throughput: 2 cycles per instruction. With HALT at index n, done rises on the (2n+2)th edge after the edge that samples start.
- prog_we while busy=1 is dropped, so the store is never modified mid-run. Writes in IDLE, DONE or ERR take effect on the next edge.
- start while busy=1 is ignored.
- start and prog_we in the same cycle while idle: the write completes and the run starts; slot 0 is read no earlier than ISSUE, 2 cycles later.
- Reset mid-run: immediate return to IDLE with all outputs at reset values, and calc_apply drops asynchronously.
- Arithmetic is performed by the calculator only; this block does no data arithmetic.

Optional Feature:
- Macro: CALC_SEQ_SINGLE_STEP_EN.
- When defined: adds input step (1 bit). ISSUE waits, with no apply and pc held, until step=1, then behaves as normal. HALT also waits for step. CLEAR and CHECK are unaffected.
- When undefined: no step port; ISSUE proceeds immediately.

Decomposition:
- Shared package calc_pkg holds:
  - op constants: OP_PUSH=0, OP_POP=1, OP_ADD=2, OP_MUL=3, OP_SUB=4, OP_DIV=5, OP_MOD=6, OP_HALT=7;
  - state encodings IDLE, CLEAR, ISSUE, CHECK, DONE, ERR;
  - default QUEUE_SIZE=5.
- One sub-module: calc_prog_mem, the PROG_DEPTH x (3+WIDTH) store with a synchronous write port and a combinational read port.

Test Plan:
- Program push 3, push 4, add, HALT; start -> calc_apply pulses 3 times, done=1 after 8 edges, result=7, pc=3, error=0.
- Program push 2, push 9, sub, HALT -> result=7 (9-2); repeat with mul on 20 and 13 -> result=4 (260 mod 256).
- Program push 0, push 5, div -> error=1 at CHECK of pc=2, done=0, busy=0, no further apply.
- Program six pushes -> error=1 with pc=5; program a single pop -> error=1 with pc=0.
- Start while busy, and prog_we to slot 0 mid-run -> both ignored, result unchanged; re-run after DONE pulses calc_reset, and the second run gives the same result.
- Assert reset during CHECK -> busy, done, error and calc_apply are 0 immediately; the next start runs from pc=0.
